// File: rtl/cpu_issue_scoreboard.sv
// Register-hazard issue scoreboard. Holds a pre-decoded instruction until
// none of its source registers has a pending write, then moves it into a
// one-entry registered output slot. Each register has a small saturating
// pending-write counter, and a global count bounds the in-flight writes.
module cpu_issue_scoreboard #(
  parameter int REGISTER_COUNT  = 32,
  parameter int PENDING_WIDTH   = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DATA_WIDTH      = 96,
  localparam int IDX_W = $clog2(REGISTER_COUNT),
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [IDX_W-1:0]      i_rs1,
  input  logic [IDX_W-1:0]      i_rs2,
  input  logic [IDX_W-1:0]      i_rd,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [IDX_W-1:0]      o_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_wb_valid,
  input  logic [IDX_W-1:0]      i_wb_rd,
  input  logic                  i_flush,
  output logic [OUT_W-1:0]      o_outstanding,
  output logic                  o_error
);

  localparam logic [PENDING_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [PENDING_WIDTH-1:0] CNT_ONE   = PENDING_WIDTH'(1);
  localparam logic [OUT_W-1:0]         TOTAL_MAX = OUT_W'(MAX_OUTSTANDING);

  logic [PENDING_WIDTH-1:0] cnt [REGISTER_COUNT];
  logic [OUT_W-1:0]         total;

  logic wb_live, wb_hit, wb_err;
  logic busy1, busy2, rd_full, total_full, hazard;
  logic accept, inc;

  // A writeback only retires something when the target counter is nonzero;
  // a writeback to an idle register is a protocol error and changes nothing.
  assign wb_live = i_wb_valid && (i_wb_rd != '0);
  assign wb_hit  = wb_live && (cnt[i_wb_rd] != '0);
  assign wb_err  = wb_live && (cnt[i_wb_rd] == '0);

  // A source is busy unless its last pending write retires this very cycle,
  // which lets a same-cycle writeback release the dependent instruction.
  assign busy1 = (i_rs1 != '0) && (cnt[i_rs1] != '0) &&
                 !(wb_hit && (i_wb_rd == i_rs1) && (cnt[i_rs1] == CNT_ONE));
  assign busy2 = (i_rs2 != '0) && (cnt[i_rs2] != '0) &&
                 !(wb_hit && (i_wb_rd == i_rs2) && (cnt[i_rs2] == CNT_ONE));

  // Capacity checks: a same-cycle retirement frees the slot it needs.
  assign rd_full    = (i_rd != '0) && (cnt[i_rd] == CNT_MAX) &&
                      !(wb_hit && (i_wb_rd == i_rd));
  assign total_full = (i_rd != '0) && (total == TOTAL_MAX) && !wb_hit;

  assign hazard  = busy1 || busy2 || rd_full || total_full;
  assign o_ready = !hazard && (!o_valid || i_ready) && !i_flush;
  assign accept  = i_valid && o_ready;
  assign inc     = accept && (i_rd != '0);

  assign o_outstanding = total;

  // Per-register pending-write counters; accept and retire on the same
  // register cancel out.
  always_ff @(posedge i_clock) begin
    for (int r = 0; r < REGISTER_COUNT; r++) begin
      if (i_reset || i_flush) begin
        cnt[r] <= '0;
      end else if ((inc && (i_rd == IDX_W'(r))) != (wb_hit && (i_wb_rd == IDX_W'(r)))) begin
        if (inc && (i_rd == IDX_W'(r))) cnt[r] <= cnt[r] + CNT_ONE;
        else                            cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

  // Global outstanding-write count, same cancel rule as the per-register ones.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush)  total <= '0;
    else if (inc && !wb_hit) total <= total + OUT_W'(1);
    else if (!inc && wb_hit) total <= total - OUT_W'(1);
  end

  // Sticky error; a writeback coinciding with a flush is discarded entirely.
  always_ff @(posedge i_clock) begin
    if (i_reset)                 o_error <= 1'b0;
    else if (wb_err && !i_flush) o_error <= 1'b1;
  end

  // One-entry issue slot; payload only changes on accept, so it stays
  // stable while the backend is stalling.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_rd    <= '0;
      o_data  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_rd    <= i_rd;
      o_data  <= i_data;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_issue_scoreboard.sv
// Self-checking bench for cpu_issue_scoreboard: directed scenarios followed
// by a randomized phase, all compared against a pending-count reference model.
module tb_cpu_issue_scoreboard;

  localparam int NR   = 32;
  localparam int MAXO = 8;
  localparam int SAT  = 3;
  localparam int DW   = 96;

  logic          clk = 1'b0;
  logic          rst, v, rdy, wbv, fl;
  logic [4:0]    rs1, rs2, rd, wbrd;
  logic [DW-1:0] din;
  logic          o_ready, o_valid, o_error;
  logic [4:0]    o_rd;
  logic [DW-1:0] o_data;
  logic [3:0]    o_outstanding;

  always #5 clk = ~clk;

  cpu_issue_scoreboard dut (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .o_ready(o_ready),
    .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_data(din),
    .o_valid(o_valid), .i_ready(rdy), .o_rd(o_rd), .o_data(o_data),
    .i_wb_valid(wbv), .i_wb_rd(wbrd), .i_flush(fl),
    .o_outstanding(o_outstanding), .o_error(o_error)
  );

  int passed = 0;
  int fails  = 0;
  int checks = 0;

  // Reference model: pending writes per register, plus the issue slot.
  int            mcnt [NR];
  bit            mvalid, merr;
  logic [4:0]    mrd;
  logic [DW-1:0] mdata;
  logic          last_ready;
  logic [DW-1:0] d1, d2;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int msum();
    int s = 0;
    foreach (mcnt[i]) s += mcnt[i];
    return s;
  endfunction

  function automatic bit mbusy(input int r);
    int eff;
    if (r == 0) return 1'b0;
    eff = mcnt[r] - ((wbv && int'(wbrd) == r && mcnt[r] > 0) ? 1 : 0);
    return eff != 0;
  endfunction

  function automatic bit mready();
    bit wbdec, rdfull, totfull;
    wbdec   = wbv && wbrd != 0 && mcnt[wbrd] > 0;
    rdfull  = rd != 0 && mcnt[rd] == SAT && !(wbv && wbrd == rd);
    totfull = rd != 0 && msum() == MAXO && !wbdec;
    return !(mbusy(int'(rs1)) || mbusy(int'(rs2)) || rdfull || totfull) &&
           (!mvalid || rdy) && !fl;
  endfunction

  task automatic set_in(input bit vv, input int r1, input int r2, input int d,
                        input bit rr, input bit wv, input int wr, input bit f);
    v = vv; rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(d);
    rdy = rr; wbv = wv; wbrd = 5'(wr); fl = f;
    din = {$urandom, $urandom, $urandom};
  endtask

  // One clock: check o_ready mid-cycle, advance the model at the edge,
  // then check registered outputs just after it.
  task automatic cyc();
    bit er, acc;
    er = 1'b0;
    @(negedge clk);
    if (!rst) begin
      er = mready();
      chk("o_ready", o_ready, er);
      last_ready = o_ready;
    end
    acc = v && er;
    @(posedge clk);
    if (rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mvalid = 0; merr = 0; mrd = '0; mdata = '0;
    end else if (fl) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mvalid = 0;
    end else begin
      if (wbv && wbrd != 0) begin
        if (mcnt[wbrd] > 0) mcnt[wbrd]--;
        else merr = 1;
      end
      if (acc) begin
        if (rd != 0) mcnt[rd]++;
        mvalid = 1; mrd = rd; mdata = din;
      end else if (rdy) begin
        mvalid = 0;
      end
    end
    #1;
    chk("o_valid", o_valid, mvalid);
    chk("o_outstanding", o_outstanding, msum());
    chk("o_error", o_error, merr);
    if (mvalid) begin
      chk("o_rd", o_rd, mrd);
      chk("o_data", o_data, mdata);
    end
  endtask

  task automatic rand_step();
    int s, r, wr;
    bit wv;
    wv = 0; wr = 0;
    if ($urandom_range(0, 1) == 1) begin
      s = $urandom_range(0, 30);
      for (int k = 0; k < 31; k++) begin
        r = 1 + ((s + k) % 31);
        if (mcnt[r] > 0) begin wv = 1; wr = r; break; end
      end
    end
    if ($urandom_range(0, 99) == 0) begin wv = 1; wr = $urandom_range(0, 31); end
    set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9), $urandom_range(0, 9),
           $urandom_range(0, 9), $urandom_range(0, 3) != 0, wv, wr,
           $urandom_range(0, 39) == 0);
    cyc();
  endtask

  initial begin
    foreach (mcnt[i]) mcnt[i] = 0;
    mvalid = 0; merr = 0; mrd = '0; mdata = '0; last_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(); cyc();
    chk("rst_o_rd", o_rd, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_outstanding", o_outstanding, 0);
    chk("rst_o_error", o_error, 0);
    rst = 1'b0;

    // Independent stream: back-to-back issue
    for (int i = 1; i <= 3; i++) begin
      set_in(1, 0, 0, i, 1, 0, 0, 0); cyc();
      chk("indep_ready", last_ready, 1);
      chk("indep_valid", o_valid, 1);
      chk("indep_rd", o_rd, i);
    end
    chk("indep_out3", o_outstanding, 3);
    for (int i = 1; i <= 3; i++) begin
      set_in(0, 0, 0, 0, 1, 1, i, 0); cyc();
    end
    chk("indep_out0", o_outstanding, 0);

    // RAW stall with writeback bypass
    set_in(1, 0, 0, 5, 1, 0, 0, 0); cyc();
    set_in(1, 5, 0, 6, 1, 0, 0, 0); cyc();
    chk("raw_stall", last_ready, 0);
    cyc();
    chk("raw_stall2", last_ready, 0);
    set_in(1, 5, 0, 6, 1, 1, 5, 0); cyc();
    chk("raw_bypass", last_ready, 1);
    set_in(0, 6, 0, 0, 1, 0, 0, 0); cyc();
    chk("raw_cnt6_busy", last_ready, 0);
    chk("raw_out", o_outstanding, 1);
    set_in(0, 0, 0, 0, 1, 1, 6, 0); cyc();

    // Counter saturation
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 7, 1, 0, 0, 0); cyc();
    end
    set_in(1, 0, 0, 7, 1, 0, 0, 0); cyc();
    chk("sat_stall", last_ready, 0);
    chk("sat_out", o_outstanding, 3);
    set_in(1, 0, 0, 7, 1, 1, 7, 0); cyc();
    chk("sat_release", last_ready, 1);
    chk("sat_out_net", o_outstanding, 3);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1, 1, 7, 0); cyc();
    end
    chk("sat_drained", o_outstanding, 0);

    // Total limit
    for (int i = 1; i <= 8; i++) begin
      set_in(1, 0, 0, i, 1, 0, 0, 0); cyc();
    end
    set_in(1, 0, 0, 9, 1, 0, 0, 0); cyc();
    chk("tot_stall", last_ready, 0);
    chk("tot_out", o_outstanding, 8);
    set_in(1, 0, 0, 9, 1, 1, 1, 0); cyc();
    chk("tot_release", last_ready, 1);
    chk("tot_out_net", o_outstanding, 8);
    for (int i = 2; i <= 9; i++) begin
      set_in(0, 0, 0, 0, 1, 1, i, 0); cyc();
    end
    chk("tot_drained", o_outstanding, 0);

    // Backpressure: slot held, then back-to-back replacement
    set_in(1, 0, 0, 0, 0, 0, 0, 0); d1 = din; cyc();
    chk("bp_valid", o_valid, 1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("bp_stall", last_ready, 0);
    chk("bp_hold", o_data, d1);
    set_in(1, 0, 0, 0, 1, 0, 0, 0); d2 = din; cyc();
    chk("bp_replace_ready", last_ready, 1);
    chk("bp_replace", o_data, d2);

    // Flush with a coincident writeback, then a stray writeback
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 0, 0, i, 1, 0, 0, 0); cyc();
    end
    chk("fl_pre_out", o_outstanding, 4);
    chk("fl_pre_valid", o_valid, 1);
    set_in(1, 0, 0, 5, 1, 1, 1, 1); cyc();
    chk("fl_ready", last_ready, 0);
    chk("fl_valid", o_valid, 0);
    chk("fl_out", o_outstanding, 0);
    chk("fl_err", o_error, 0);
    set_in(0, 0, 0, 0, 1, 1, 3, 0); cyc();
    chk("err_set", o_error, 1);
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc();
    chk("err_sticky", o_error, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("err_clear", o_error, 0);

    // Randomized traffic against the model
    repeat (600) rand_step();

    // Mid-operation reset clears everything
    rst = 1'b1; set_in(0, 0, 0, 0, 1, 0, 0, 0); cyc(); rst = 1'b0;
    chk("final_rst_out", o_outstanding, 0);
    chk("final_rst_valid", o_valid, 0);
    chk("final_rst_err", o_error, 0);
    chk("final_rst_data", o_data, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
